binarize_ctrl: RTL and testbench
================================

# binarize_ctrl

Frame-level controller for the binarize datapath. Accepts the raw 8-bit gray pixel stream, frames it into IMAGE_WIDTH × IMAGE_HEIGHT frames, and forwards in-frame pixels to the binarizer with row/column tags. It supplies the binarizer's per-frame threshold, either fixed from a config write (manual) or derived from the previous frame's min/max (auto). Threshold changes take effect only at frame boundaries.

## Interface
- IMAGE_WIDTH, 320, pixels per row (≥2)
- IMAGE_HEIGHT, 240, rows per frame (≥2)
- DEFAULT_THRESH, 128, threshold after reset
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a frame when IDLE
- stop  in  1  pulse; aborts the current frame / ends continuous mode
- cfg_valid  in  1  config write strobe; cfg_ready is always 1
- cfg_ready  out  1  tied high
- cfg_auto  in  1  1 = auto (midrange) threshold, 0 = manual
- cfg_cont  in  1  1 = restart automatically after each frame
- cfg_thresh  in  8  manual threshold
- gray_valid  in  1  input pixel strobe
- gray  in  8  input pixel
- pix_valid  out  1  pixel to binarizer
- pix_out  out  8  pixel value
- pix_row  out  $clog2(IMAGE_HEIGHT)  row of pix_out
- pix_col  out  $clog2(IMAGE_WIDTH)  column of pix_out
- thresh  out  8  active threshold, constant within a frame
- frame_start  out  1  pulse with the frame's first pix_valid
- frame_done  out  1  pulse with the frame's last pix_valid
- busy  out  1  high in RUN and UPDATE
- frame_min, frame_max  out  8  stats of the last completed frame
- drop  out  1  sticky: a gray_valid was discarded outside RUN; cleared by start

## Operation
- Pending registers (auto, cont, thresh) are written on every cfg_valid. Active registers load from pending on every entry to RUN.
- States: IDLE, RUN, UPDATE.
- IDLE → RUN on start. Clear row/col, min←255, max←0. Load active registers.
- RUN: each gray_valid forwards the pixel and advances col. Col wraps at IMAGE_WIDTH−1, which increments row. min/max update on the same edge.
- RUN → UPDATE on the edge that accepts pixel (IMAGE_WIDTH−1, IMAGE_HEIGHT−1).
- RUN → IDLE on stop. No frame_done is issued. frame_min/max are not updated.
- UPDATE lasts one cycle:
  - frame_min/max ← min/max.
  - If active auto is set, pending thresh ← (min+max+1)>>1, computed 9-bit and truncated to 8 bits.
  - A cfg_valid in the same cycle overrides the computed value.
  - Next state is RUN if active cont is set and stop is low; otherwise IDLE.
- gray_valid in IDLE or UPDATE discards the pixel and sets drop.
- start in RUN or UPDATE is ignored.
- stop together with start in IDLE: stop wins, and the block stays in IDLE.
- rst returns to IDLE from any state, mid-frame included. All pending/active registers return to defaults.

## Timing
- Reset values:
  - pix_valid, frame_start, frame_done, busy, drop = 0.
  - pix_out, pix_row, pix_col = 0; frame_min = 0, frame_max = 0.
  - thresh = DEFAULT_THRESH, auto = 0, cont = 0.
- Latency: pix_* and frame_start/frame_done appear 1 cycle after the accepting gray_valid edge.
- frame_done coincides with the UPDATE cycle. frame_min/max are valid from the cycle after UPDATE.
- thresh changes only on the edge entering RUN, so it is stable for every pix_valid of a frame.
- In continuous mode, UPDATE costs one cycle, and a gray_valid in that cycle is dropped. Upstream must leave ≥1 idle cycle between frames.
- Back-to-back gray_valid is supported at one pixel per clock.

## Structure
- Shared package binarize_pkg:
  - state enum (IDLE/RUN/UPDATE);
  - COL_W/ROW_W width helpers, defined as $clog2 of the parameters with a minimum of 1;
  - DEFAULT_THRESH constant.
- Sub-module frame_minmax tracks min/max, with ports clear, en, pix, min, max.
- Everything else stays in the controller.

## Test plan
- Manual frame, 4×2 config, cfg_thresh=100, start, 8 pixels 0..7: exactly 8 pix_valid with row/col (0,0)…(1,3), thresh=100 throughout, frame_start on pixel 0, frame_done on pixel 7, busy drops after UPDATE.
- Auto continuous, pixels spanning 10..200 in frame 1: frame_min=10, frame_max=200, thresh=105 for all of frame 2.
- cfg_valid with cfg_thresh=50 mid-frame: thresh stays at its old value until the next RUN entry, then reads 50. A cfg write during UPDATE overrides the auto result.
- stop after 3 pixels: return to IDLE, no frame_done, frame_min/max unchanged. Next start restarts at (0,0).
- gray_valid in IDLE and in the UPDATE cycle: no pix_valid, drop=1. drop clears on start.
- rst asserted mid-frame: all outputs at reset values next cycle; thresh=128.

Source files
------------

// File: rtl/binarize_pkg.sv
// Shared types and helpers for the binarize frame controller.
// Holds the controller state encoding, index-width helpers and threshold math.
package binarize_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      UPDATE = 2'd2
   } state_e;

   localparam int DEFAULT_THRESH = 128;

   // Index widths never collapse to zero bits, even for degenerate sizes.
   function automatic int col_w(input int image_width);
      return (image_width <= 2) ? 1 : $clog2(image_width);
   endfunction

   function automatic int row_w(input int image_height);
      return (image_height <= 2) ? 1 : $clog2(image_height);
   endfunction

   // Rounded midpoint of the frame range; the 9-bit sum keeps the carry.
   function automatic logic [7:0] midrange(input logic [7:0] lo, input logic [7:0] hi);
      logic [8:0] sum;
      sum = {1'b0, lo} + {1'b0, hi} + 9'd1;
      return sum[8:1];
   endfunction

endpackage

// File: rtl/binarize_ctrl_frame_minmax.sv
// Running minimum/maximum of the pixels accepted in the current frame.
// clear restarts the range at the empty-frame values (min=255, max=0).
module frame_minmax (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       en,
   input  logic [7:0] pix,
   output logic [7:0] min,
   output logic [7:0] max
);

   logic [7:0] min_q, min_d;
   logic [7:0] max_q, max_d;

   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if (clear) begin
         min_d = 8'hFF;
         max_d = 8'h00;
      end else if (en) begin
         if (pix < min_q) min_d = pix;
         if (pix > max_q) max_d = pix;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         min_q <= 8'hFF;
         max_q <= 8'h00;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign min = min_q;
   assign max = max_q;

endmodule

// File: rtl/binarize_ctrl.sv
// Frame controller for the binarize datapath: frames the gray stream, tags pixels
// with row/column and supplies a per-frame threshold (manual or auto midrange).
module binarize_ctrl #(
   parameter int IMAGE_WIDTH    = 320,
   parameter int IMAGE_HEIGHT   = 240,
   parameter int DEFAULT_THRESH = binarize_pkg::DEFAULT_THRESH
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          start,
   input  logic                                          stop,
   input  logic                                          cfg_valid,
   output logic                                          cfg_ready,
   input  logic                                          cfg_auto,
   input  logic                                          cfg_cont,
   input  logic [7:0]                                    cfg_thresh,
   input  logic                                          gray_valid,
   input  logic [7:0]                                    gray,
   output logic                                          pix_valid,
   output logic [7:0]                                    pix_out,
   output logic [binarize_pkg::row_w(IMAGE_HEIGHT)-1:0]  pix_row,
   output logic [binarize_pkg::col_w(IMAGE_WIDTH)-1:0]   pix_col,
   output logic [7:0]                                    thresh,
   output logic                                          frame_start,
   output logic                                          frame_done,
   output logic                                          busy,
   output logic [7:0]                                    frame_min,
   output logic [7:0]                                    frame_max,
   output logic                                          drop
);

   import binarize_pkg::*;

   localparam int COL_W = col_w(IMAGE_WIDTH);
   localparam int ROW_W = row_w(IMAGE_HEIGHT);
   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMAGE_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMAGE_HEIGHT - 1);
   localparam logic [7:0]       THRESH_RST = 8'(DEFAULT_THRESH);

   state_e            state_q, state_d;
   logic              pend_auto_q, pend_auto_d;
   logic              pend_cont_q, pend_cont_d;
   logic [7:0]        pend_thresh_q, pend_thresh_d;
   logic              act_auto_q, act_cont_q;
   logic [7:0]        thresh_q;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              pix_valid_q, pix_valid_d;
   logic [7:0]        pix_out_q, pix_out_d;
   logic [ROW_W-1:0]  pix_row_q, pix_row_d;
   logic [COL_W-1:0]  pix_col_q, pix_col_d;
   logic              frame_start_q, frame_start_d;
   logic              frame_done_q, frame_done_d;
   logic [7:0]        frame_min_q, frame_min_d;
   logic [7:0]        frame_max_q, frame_max_d;
   logic              drop_q, drop_d;
   logic              enter_run, accept, last_pix;
   logic [7:0]        cur_min, cur_max;

   assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);

   frame_minmax u_minmax (
      .clk   (clk),
      .rst   (rst),
      .clear (enter_run),
      .en    (accept),
      .pix   (gray),
      .min   (cur_min),
      .max   (cur_max)
   );

   always_comb begin
      state_d       = state_q;
      pend_auto_d   = pend_auto_q;
      pend_cont_d   = pend_cont_q;
      pend_thresh_d = pend_thresh_q;
      col_d         = col_q;
      row_d         = row_q;
      pix_valid_d   = 1'b0;
      pix_out_d     = pix_out_q;
      pix_row_d     = pix_row_q;
      pix_col_d     = pix_col_q;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;
      frame_min_d   = frame_min_q;
      frame_max_d   = frame_max_q;
      drop_d        = drop_q;
      enter_run     = 1'b0;
      accept        = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               enter_run = 1'b1;
               drop_d    = 1'b0;
            end
            if (gray_valid) drop_d = 1'b1;
         end
         RUN: begin
            // stop has priority over a pixel arriving on the same edge
            if (stop) begin
               state_d = IDLE;
            end else if (gray_valid) begin
               accept        = 1'b1;
               pix_valid_d   = 1'b1;
               pix_out_d     = gray;
               pix_row_d     = row_q;
               pix_col_d     = col_q;
               frame_start_d = (row_q == '0) && (col_q == '0);
               frame_done_d  = last_pix;
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
               end else begin
                  col_d = col_q + COL_W'(1);
               end
               if (last_pix) state_d = UPDATE;
            end
         end
         UPDATE: begin
            frame_min_d = cur_min;
            frame_max_d = cur_max;
            if (gray_valid) drop_d = 1'b1;
            if (act_auto_q) pend_thresh_d = midrange(cur_min, cur_max);
            if (act_cont_q && !stop) enter_run = 1'b1;
            else state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A config write lands after the auto result so it overrides it.
      if (cfg_valid) begin
         pend_auto_d   = cfg_auto;
         pend_cont_d   = cfg_cont;
         pend_thresh_d = cfg_thresh;
      end

      if (enter_run) begin
         state_d = RUN;
         col_d   = '0;
         row_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pend_auto_q   <= 1'b0;
         pend_cont_q   <= 1'b0;
         pend_thresh_q <= THRESH_RST;
         act_auto_q    <= 1'b0;
         act_cont_q    <= 1'b0;
         thresh_q      <= THRESH_RST;
         col_q         <= '0;
         row_q         <= '0;
         pix_valid_q   <= 1'b0;
         pix_out_q     <= 8'h00;
         pix_row_q     <= '0;
         pix_col_q     <= '0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_min_q   <= 8'h00;
         frame_max_q   <= 8'h00;
         drop_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pend_auto_q   <= pend_auto_d;
         pend_cont_q   <= pend_cont_d;
         pend_thresh_q <= pend_thresh_d;
         col_q         <= col_d;
         row_q         <= row_d;
         pix_valid_q   <= pix_valid_d;
         pix_out_q     <= pix_out_d;
         pix_row_q     <= pix_row_d;
         pix_col_q     <= pix_col_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         frame_min_q   <= frame_min_d;
         frame_max_q   <= frame_max_d;
         drop_q        <= drop_d;
         // Active settings take the freshest pending values, including a same-cycle write.
         if (enter_run) begin
            act_auto_q <= pend_auto_d;
            act_cont_q <= pend_cont_d;
            thresh_q   <= pend_thresh_d;
         end
      end
   end

   assign cfg_ready   = 1'b1;
   assign pix_valid   = pix_valid_q;
   assign pix_out     = pix_out_q;
   assign pix_row     = pix_row_q;
   assign pix_col     = pix_col_q;
   assign thresh      = thresh_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign busy        = (state_q != IDLE);
   assign frame_min   = frame_min_q;
   assign frame_max   = frame_max_q;
   assign drop        = drop_q;

endmodule

// File: tb/tb_binarize_ctrl.sv
// Bench for binarize_ctrl on a 4x2 frame: directed scenarios then random traffic,
// each cycle compared against a frame-level reference model.
module tb_binarize_ctrl;

   localparam int W    = 4;
   localparam int H    = 2;
   localparam int NPIX = W * H;

   logic       clk = 1'b0;
   logic       rst, start, stop, cfg_valid, cfg_auto, cfg_cont, gray_valid;
   logic [7:0] cfg_thresh, gray;
   logic       cfg_ready, pix_valid, frame_start, frame_done, busy, drop;
   logic [7:0] pix_out, thresh, frame_min, frame_max;
   logic [0:0] pix_row;
   logic [1:0] pix_col;

   int n_chk  = 0;
   int n_pass = 0;
   int npix_seen;

   // reference model state
   int       ph;          // 0 idle, 1 in frame, 2 frame wrap-up cycle
   int       frm[$];
   int       p_auto, p_cont, p_thr, a_auto, a_cont, a_thr;
   int       e_pv, e_fs, e_fd, e_pix, e_row, e_col, e_fmin, e_fmax, e_drop;

   binarize_ctrl #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DEFAULT_THRESH(128)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_auto(cfg_auto),
      .cfg_cont(cfg_cont), .cfg_thresh(cfg_thresh),
      .gray_valid(gray_valid), .gray(gray),
      .pix_valid(pix_valid), .pix_out(pix_out), .pix_row(pix_row), .pix_col(pix_col),
      .thresh(thresh), .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
      .frame_min(frame_min), .frame_max(frame_max), .drop(drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic model_step();
      int mn, mx;
      bit go;
      go = 0; e_pv = 0; e_fs = 0; e_fd = 0;
      if (rst) begin
         ph = 0; frm.delete();
         p_auto = 0; p_cont = 0; p_thr = 128;
         a_auto = 0; a_cont = 0; a_thr = 128;
         e_pix = 0; e_row = 0; e_col = 0; e_fmin = 0; e_fmax = 0; e_drop = 0;
         return;
      end
      case (ph)
         0: begin
            if (start && !stop) begin go = 1; e_drop = 0; end
            if (gray_valid) e_drop = 1;
         end
         1: begin
            if (stop) ph = 0;
            else if (gray_valid) begin
               e_pv = 1; e_pix = gray;
               e_row = frm.size() / W; e_col = frm.size() % W;
               e_fs = (frm.size() == 0); e_fd = (frm.size() == NPIX - 1);
               frm.push_back(gray);
               if (frm.size() == NPIX) ph = 2;
            end
         end
         default: begin
            mn = 255; mx = 0;
            foreach (frm[i]) begin
               if (frm[i] < mn) mn = frm[i];
               if (frm[i] > mx) mx = frm[i];
            end
            e_fmin = mn; e_fmax = mx;
            if (gray_valid) e_drop = 1;
            if (a_auto != 0) p_thr = ((mn + mx + 1) / 2) % 256;
            go = (a_cont != 0) && !stop;
            if (!go) ph = 0;
         end
      endcase
      if (cfg_valid) begin p_auto = cfg_auto; p_cont = cfg_cont; p_thr = cfg_thresh; end
      if (go) begin
         a_auto = p_auto; a_cont = p_cont; a_thr = p_thr;
         frm.delete(); ph = 1;
      end
   endtask

   task automatic compare();
      chk("pix_valid", pix_valid, e_pv);
      chk("frame_start", frame_start, e_fs);
      chk("frame_done", frame_done, e_fd);
      chk("busy", busy, ph != 0);
      chk("thresh", thresh, a_thr);
      chk("frame_min", frame_min, e_fmin);
      chk("frame_max", frame_max, e_fmax);
      chk("drop", drop, e_drop);
      chk("cfg_ready", cfg_ready, 1);
      if (e_pv || rst) begin
         chk("pix_out", pix_out, e_pix);
         chk("pix_row", pix_row, e_row);
         chk("pix_col", pix_col, e_col);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare();
      if (pix_valid) npix_seen++;
      rst = 0; start = 0; stop = 0; cfg_valid = 0; gray_valid = 0;
   endtask

   task automatic cfg(input int a, input int c, input int t);
      cfg_valid = 1; cfg_auto = a[0]; cfg_cont = c[0]; cfg_thresh = t[7:0];
   endtask

   task automatic push(input int v);
      gray_valid = 1; gray = v[7:0];
      tick();
   endtask

   initial begin
      int f1[8];
      f1 = '{50, 10, 90, 200, 120, 30, 60, 70};
      rst = 1; start = 0; stop = 0; cfg_valid = 0; cfg_auto = 0; cfg_cont = 0;
      cfg_thresh = 0; gray_valid = 0; gray = 0;
      tick();
      rst = 1; tick();
      chk("rst_thresh", thresh, 128);

      // manual single frame
      cfg(0, 0, 100); tick();
      start = 1; tick();
      chk("man_thresh", thresh, 100);
      npix_seen = 0;
      for (int i = 0; i < NPIX; i++) push(i);
      chk("man_done_last", frame_done, 1);
      tick();
      chk("man_busy_after", busy, 0);
      chk("man_npix", npix_seen, NPIX);

      // auto continuous: frame 1 spans 10..200
      cfg(1, 1, 0); tick();
      start = 1; tick();
      foreach (f1[i]) push(f1[i]);
      tick();
      chk("auto_min", frame_min, 10);
      chk("auto_max", frame_max, 200);
      chk("auto_thresh", thresh, 105);
      // frame 2 with a mid-frame config write that must wait for the boundary
      for (int i = 0; i < NPIX; i++) begin
         if (i == 3) cfg(1, 1, 77);
         push(20 + i);
      end
      cfg(0, 1, 50); tick();
      chk("override_thresh", thresh, 50);

      // abort after 3 pixels
      for (int i = 0; i < 3; i++) push(9 + i);
      stop = 1; tick();
      chk("stop_busy", busy, 0);
      chk("stop_min_kept", frame_min, 20);
      gray_valid = 1; gray = 8'd33; tick();
      chk("drop_idle", drop, 1);
      cfg(0, 0, 60); tick();
      start = 1; tick();
      chk("drop_clr", drop, 0);
      push(1); push(2);
      rst = 1; tick();
      chk("rst_mid_thresh", thresh, 128);
      chk("rst_mid_busy", busy, 0);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         start      = ($urandom % 8) == 0;
         stop       = ($urandom % 50) == 0;
         gray_valid = ($urandom % 4) != 0;
         gray       = 8'($urandom);
         if (($urandom % 12) == 0)
            cfg(int'($urandom % 2), int'(($urandom % 3) != 0), int'($urandom % 256));
         rst        = ($urandom % 400) == 0;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
